// File: rtl/flip_literal_selector_pkg.sv
// Shared definitions for the WalkSAT flip-literal selector: widths, literal
// field helpers, flip-kind encodings and the FSM state encoding.
package flip_literal_selector_pkg;

  localparam int NSAT                  = 3;
  localparam int LITERAL_ADDRESS_WIDTH = 12;
  localparam int VAR_WIDTH             = LITERAL_ADDRESS_WIDTH - 1;
  localparam int BREAK_WIDTH           = 8;
  localparam int RANDOM_NUM_WIDTH      = 18;
  localparam int NOISE_WIDTH           = 8;
  localparam int SLOT_WIDTH            = (NSAT > 1) ? $clog2(NSAT) : 1;
  localparam int COUNT_WIDTH           = $clog2(NSAT + 1);

  typedef logic [LITERAL_ADDRESS_WIDTH-1:0] lit_t;
  typedef logic [VAR_WIDTH-1:0]             var_t;
  typedef logic [BREAK_WIDTH-1:0]           break_t;
  typedef logic [SLOT_WIDTH-1:0]            slot_t;
  typedef logic [COUNT_WIDTH-1:0]           count_t;

  typedef enum logic [1:0] {
    KIND_FREEBIE = 2'd0,
    KIND_RANDOM  = 2'd1,
    KIND_GREEDY  = 2'd2,
    KIND_ERROR   = 2'd3
  } flip_kind_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_OUTPUT = 3'd4;

  // Bit 0 of a literal address is its polarity.
  function automatic logic lit_polarity(input lit_t lit);
    return lit[0];
  endfunction

  // The remaining bits name the variable.
  function automatic var_t lit_var(input lit_t lit);
    return lit[LITERAL_ADDRESS_WIDTH-1:1];
  endfunction

  // An all-zero literal marks an empty clause slot.
  function automatic logic lit_used(input lit_t lit);
    return lit != '0;
  endfunction

endpackage

// File: rtl/flip_literal_selector_if.sv
// Break-RAM read port and flip hand-off bundle. The master side is the
// selector; the slave side is the RAM plus the downstream flip stage.
interface flip_literal_selector_if;
  import flip_literal_selector_pkg::*;

  logic       bc_rd_en_o;
  var_t       bc_rd_addr_o;
  break_t     bc_rd_data_i;
  logic       flip_valid_o;
  logic       flip_ready_i;
  var_t       flip_var_o;
  logic [1:0] flip_kind_o;

  modport master (
    output bc_rd_en_o, bc_rd_addr_o, flip_valid_o, flip_var_o, flip_kind_o,
    input  bc_rd_data_i, flip_ready_i
  );

  modport slave (
    input  bc_rd_en_o, bc_rd_addr_o, flip_valid_o, flip_var_o, flip_kind_o,
    output bc_rd_data_i, flip_ready_i
  );

endinterface

// File: rtl/flip_literal_decide.sv
// Combinational WalkSAT candidate picks over the registered breaks of one
// clause: lowest freebie slot, noisy random slot and lowest minimum-break slot.
module flip_literal_decide
  import flip_literal_selector_pkg::*;
(
  input  logic [NSAT-1:0] i_used,
  input  break_t          i_breaks [NSAT],
  input  logic [7:0]      i_rand_hi,
  output count_t          o_used_cnt,
  output logic            o_free_found,
  output slot_t           o_free_slot,
  output slot_t           o_random_slot,
  output slot_t           o_greedy_slot
);

  logic [15:0] w_scaled;
  count_t      w_rand_idx;
  count_t      w_seen;
  logic        w_rand_found;
  logic        w_greedy_found;
  break_t      w_min_break;

  // Count used slots and find the lowest used slot with zero break.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    o_used_cnt   = '0;
    o_free_found = 1'b0;
    o_free_slot  = '0;
    for (int k = 0; k < NSAT; k++) begin
      if (i_used[k]) begin
        o_used_cnt = o_used_cnt + count_t'(1);
        if (!o_free_found && i_breaks[k] == '0) begin
          o_free_found = 1'b1;
          o_free_slot  = slot_t'(k);
        end
      end
    end
  end

  // Scale the random byte into [0, used count): always strictly below the count.
  assign w_scaled   = 16'(i_rand_hi) * 16'(o_used_cnt);
  assign w_rand_idx = count_t'(w_scaled >> 8);

  // Walk used slots in ascending order and stop at the idx-th one.
  always_comb begin
    w_seen        = '0;
    w_rand_found  = 1'b0;
    o_random_slot = '0;
    for (int k = 0; k < NSAT; k++) begin
      if (i_used[k]) begin
        if (!w_rand_found && w_seen == w_rand_idx) begin
          w_rand_found  = 1'b1;
          o_random_slot = slot_t'(k);
        end
        w_seen = w_seen + count_t'(1);
      end
    end
  end

  // Minimum break over used slots; strict compare keeps the lowest slot on ties.
  always_comb begin
    w_greedy_found = 1'b0;
    w_min_break    = '0;
    o_greedy_slot  = '0;
    for (int k = 0; k < NSAT; k++) begin
      if (i_used[k] && (!w_greedy_found || i_breaks[k] < w_min_break)) begin
        w_greedy_found = 1'b1;
        w_min_break    = i_breaks[k];
        o_greedy_slot  = slot_t'(k);
      end
    end
  end

endmodule

// File: rtl/flip_literal_selector.sv
// Takes one unsatisfied clause, reads the break count of each used literal
// serially from the break RAM, applies WalkSAT selection and hands the chosen
// variable to the flip stage over a valid/ready handshake.
module flip_literal_selector
  import flip_literal_selector_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clause_valid_i,
  input  logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0] clause_i,
  input  logic [RANDOM_NUM_WIDTH-1:0]           random_i,
  input  logic [NOISE_WIDTH-1:0]                noise_i,
  input  logic                                  clear_debug_DROP_i,
  output logic                                  busy_o,
  output logic                                  debug_DROP_o,
  flip_literal_selector_if.master               bus
);

  logic [2:0]      r_state;
  slot_t           r_slot;
  var_t            r_vars [NSAT];
  logic [NSAT-1:0] r_used;
  break_t          r_breaks [NSAT];
  logic            r_cap_used;
  slot_t           r_cap_slot;
  logic            r_flip_valid;
  var_t            r_flip_var;
  flip_kind_e      r_flip_kind;
  logic            r_drop;

  logic            w_rd_en;
  count_t          w_used_cnt;
  logic            w_free_found;
  slot_t           w_free_slot;
  slot_t           w_random_slot;
  slot_t           w_greedy_slot;
  logic            w_noisy;
  slot_t           w_pick;
  flip_kind_e      w_kind;
  var_t            w_var;
  logic            w_unused_rand;

  // Only the low 16 bits of the PRNG word feed the decision.
  assign w_unused_rand = ^random_i[RANDOM_NUM_WIDTH-1:16];

  assign w_rd_en           = (r_state == ST_FETCH) && r_used[r_slot];
  assign bus.bc_rd_en_o    = w_rd_en;
  assign bus.bc_rd_addr_o  = w_rd_en ? r_vars[r_slot] : '0;
  assign bus.flip_valid_o  = r_flip_valid;
  assign bus.flip_var_o    = r_flip_var;
  assign bus.flip_kind_o   = r_flip_kind;
  assign busy_o            = (r_state != ST_IDLE);
  assign debug_DROP_o      = r_drop;

  // Sequence a clause through fetch, capture drain, decision and hand-off.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
      r_used  <= '0;
      for (int k = 0; k < NSAT; k++) r_vars[k] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clause_valid_i) begin
            r_state <= ST_FETCH;
            r_slot  <= '0;
            for (int k = 0; k < NSAT; k++) begin
              r_vars[k] <= lit_var(clause_i[k*LITERAL_ADDRESS_WIDTH +: LITERAL_ADDRESS_WIDTH]);
              r_used[k] <= lit_used(clause_i[k*LITERAL_ADDRESS_WIDTH +: LITERAL_ADDRESS_WIDTH]);
            end
          end
        end
        ST_FETCH: begin
          if (r_slot == slot_t'(NSAT - 1)) r_state <= ST_WAIT;
          else                             r_slot  <= r_slot + slot_t'(1);
        end
        ST_WAIT:   r_state <= ST_DECIDE;
        ST_DECIDE: r_state <= ST_OUTPUT;
        ST_OUTPUT: if (bus.flip_ready_i) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture each read datum one cycle after its request; the delayed tag marks a real read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cap_used <= 1'b0;
      r_cap_slot <= '0;
      // NOTE: the break file is only NSAT registers, so it is reset with everything else; a true RAM would not be.
      for (int k = 0; k < NSAT; k++) r_breaks[k] <= '0;
    end else begin
      r_cap_used <= w_rd_en;
      r_cap_slot <= r_slot;
      if (r_cap_used) r_breaks[r_cap_slot] <= bus.bc_rd_data_i;
    end
  end

  flip_literal_decide u_decide (
    .i_used        (r_used),
    .i_breaks      (r_breaks),
    .i_rand_hi     (random_i[15:8]),
    .o_used_cnt    (w_used_cnt),
    .o_free_found  (w_free_found),
    .o_free_slot   (w_free_slot),
    .o_random_slot (w_random_slot),
    .o_greedy_slot (w_greedy_slot)
  );

  assign w_noisy = (random_i[7:0] < noise_i);

  // WalkSAT priority: empty clause, then freebie, then noisy pick, then greedy.
  always_comb begin
    w_kind = KIND_ERROR;
    w_pick = '0;
    if (w_used_cnt == '0) begin
      w_kind = KIND_ERROR;
    end else if (w_free_found) begin
      w_kind = KIND_FREEBIE;
      w_pick = w_free_slot;
    end else if (w_noisy) begin
      w_kind = KIND_RANDOM;
      w_pick = w_random_slot;
    end else begin
      w_kind = KIND_GREEDY;
      w_pick = w_greedy_slot;
    end
  end

  assign w_var = (w_kind == KIND_ERROR) ? '0 : r_vars[w_pick];

  // Register the decision in DECIDE and hold it until the consumer accepts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_flip_valid <= 1'b0;
      r_flip_var   <= '0;
      r_flip_kind  <= KIND_FREEBIE;
    end else if (r_state == ST_DECIDE) begin
      r_flip_valid <= 1'b1;
      r_flip_var   <= w_var;
      r_flip_kind  <= w_kind;
    end else if (r_state == ST_OUTPUT && bus.flip_ready_i) begin
      r_flip_valid <= 1'b0;
    end
  end

  // Sticky flag for clauses that arrive while busy; clear wins over set.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                        r_drop <= 1'b0;
    else if (clear_debug_DROP_i)                      r_drop <= 1'b0;
    else if (clause_valid_i && r_state != ST_IDLE)    r_drop <= 1'b1;
  end

endmodule

// File: tb/tb_flip_literal_selector.sv
// Self-checking bench for flip_literal_selector: directed cases followed by
// randomized clauses, checked against a WalkSAT reference model.
module tb_flip_literal_selector;

  logic        clk_i;
  logic        rst_i;
  logic        clause_valid_i;
  logic [35:0] clause_i;
  logic [17:0] random_i;
  logic [7:0]  noise_i;
  logic        clear_debug_DROP_i;
  logic        busy_o;
  logic        debug_DROP_o;

  flip_literal_selector_if bus ();

  flip_literal_selector dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .clause_valid_i     (clause_valid_i),
    .clause_i           (clause_i),
    .random_i           (random_i),
    .noise_i            (noise_i),
    .clear_debug_DROP_i (clear_debug_DROP_i),
    .busy_o             (busy_o),
    .debug_DROP_o       (debug_DROP_o),
    .bus                (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] ram [2048];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Break RAM: one-cycle read latency; garbage on the bus when not reading.
  always @(posedge clk_i) begin
    if (bus.bc_rd_en_o) bus.bc_rd_data_i <= ram[bus.bc_rd_addr_o];
    else                bus.bc_rd_data_i <= 8'($urandom);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] var_of(input logic [35:0] cl, input int slot);
    return cl[12*slot + 1 +: 11];
  endfunction

  // WalkSAT reference: list the used slots, then apply the selection rules.
  function automatic void model(input logic [35:0] cl, input logic [17:0] rnd,
                                input logic [7:0] nz, output logic [1:0] kind,
                                output logic [10:0] v);
    int used[$];
    int idx;
    int best;
    kind = 2'd3;
    v    = '0;
    for (int i = 0; i < 3; i++) if (cl[12*i +: 12] != 12'd0) used.push_back(i);
    if (used.size() == 0) return;
    foreach (used[j]) begin
      if (ram[var_of(cl, used[j])] == 8'd0) begin
        kind = 2'd0;
        v    = var_of(cl, used[j]);
        return;
      end
    end
    if (rnd[7:0] < nz) begin
      idx  = (int'(rnd[15:8]) * used.size()) / 256;
      kind = 2'd1;
      v    = var_of(cl, used[idx]);
      return;
    end
    best = used[0];
    foreach (used[j]) if (ram[var_of(cl, used[j])] < ram[var_of(cl, best)]) best = used[j];
    kind = 2'd2;
    v    = var_of(cl, best);
  endfunction

  // One clause end to end; called and returning on a falling edge.
  task automatic run_txn(input string name, input logic [35:0] cl, input logic [17:0] rnd,
                         input logic [7:0] nz, input int hold, input bit drop_test);
    logic [1:0]  ek;
    logic [10:0] ev;
    logic [11:0] lit;
    model(cl, rnd, nz, ek, ev);
    clause_i         = cl;
    clause_valid_i   = 1'b1;
    noise_i          = nz;
    random_i         = 18'($urandom);
    bus.flip_ready_i = (hold == 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      clause_valid_i = 1'b0;
      if (c <= 3) begin
        lit = cl[12*(c-1) +: 12];
        check($sformatf("%s_rd_en%0d", name, c - 1), bus.bc_rd_en_o, lit != 12'd0);
        if (lit != 12'd0) check($sformatf("%s_rd_addr%0d", name, c - 1), bus.bc_rd_addr_o, lit[11:1]);
      end else begin
        check($sformatf("%s_rd_idle%0d", name, c), bus.bc_rd_en_o, 1'b0);
      end
      check($sformatf("%s_early_valid%0d", name, c), bus.flip_valid_o, 1'b0);
      random_i = (c == 5) ? rnd : 18'($urandom);
    end
    @(negedge clk_i);
    random_i = 18'($urandom);
    check({name, "_valid"}, bus.flip_valid_o, 1'b1);
    check({name, "_var"},   bus.flip_var_o,   ev);
    check({name, "_kind"},  bus.flip_kind_o,  ek);
    for (int h = 0; h < hold; h++) begin
      if (drop_test) begin
        clause_valid_i     = (h == 0 || h == 2);
        clear_debug_DROP_i = (h == 2);
        clause_i           = 36'($urandom);
      end
      random_i = 18'($urandom);
      @(negedge clk_i);
      check($sformatf("%s_hold_valid%0d", name, h), bus.flip_valid_o, 1'b1);
      check($sformatf("%s_hold_var%0d", name, h),   bus.flip_var_o,   ev);
      check($sformatf("%s_hold_kind%0d", name, h),  bus.flip_kind_o,  ek);
      if (drop_test) check($sformatf("%s_drop%0d", name, h), debug_DROP_o, h < 2);
    end
    clause_valid_i     = 1'b0;
    clear_debug_DROP_i = 1'b0;
    bus.flip_ready_i   = 1'b1;
    if (hold > 0) @(negedge clk_i);
    else          @(negedge clk_i);
    check({name, "_done_valid"}, bus.flip_valid_o, 1'b0);
    check({name, "_done_busy"},  busy_o,           1'b0);
  endtask

  task automatic set_breaks(input logic [7:0] b5, input logic [7:0] b10, input logic [7:0] b16);
    ram[5]  = b5;
    ram[10] = b10;
    ram[16] = b16;
  endtask

  initial begin
    logic [35:0] base;
    rst_i              = 1'b1;
    clause_valid_i     = 1'b0;
    clause_i           = '0;
    random_i           = '0;
    noise_i            = '0;
    clear_debug_DROP_i = 1'b0;
    bus.flip_ready_i   = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom_range(1, 255));
    base = {12'h020, 12'h015, 12'h00A};

    repeat (3) @(negedge clk_i);
    check("rst_busy",  busy_o,            1'b0);
    check("rst_valid", bus.flip_valid_o,  1'b0);
    check("rst_var",   bus.flip_var_o,    11'd0);
    check("rst_kind",  bus.flip_kind_o,   2'd0);
    check("rst_rd_en", bus.bc_rd_en_o,    1'b0);
    check("rst_addr",  bus.bc_rd_addr_o,  11'd0);
    check("rst_drop",  debug_DROP_o,      1'b0);
    rst_i = 1'b0;

    set_breaks(8'd3, 8'd0, 8'd5);
    run_txn("freebie", base, 18'h0, 8'h00, 0, 1'b0);
    check("freebie_reuse", bus.flip_var_o, 11'd10);

    set_breaks(8'd4, 8'd2, 8'd2);
    run_txn("greedy_tie", base, 18'h3FFFF, 8'h00, 0, 1'b0);

    set_breaks(8'd4, 8'd2, 8'd7);
    run_txn("noisy", base, {2'b00, 8'hAB, 8'h10}, 8'hFF, 0, 1'b0);

    set_breaks(8'd6, 8'd9, 8'd1);
    run_txn("gap_slot", {12'h020, 12'h000, 12'h00A}, {2'b00, 8'hFF, 8'h00}, 8'hFF, 0, 1'b0);

    run_txn("empty", 36'd0, 18'h0, 8'h80, 0, 1'b0);

    set_breaks(8'd3, 8'd0, 8'd5);
    run_txn("stall", base, 18'h0, 8'h00, 4, 1'b1);

    set_breaks(8'hFF, 8'hFE, 8'hFF);
    run_txn("saturated", base, 18'h0, 8'h00, 0, 1'b0);

    clause_i       = base;
    clause_valid_i = 1'b1;
    @(negedge clk_i);
    clause_valid_i = 1'b0;
    check("mid_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_busy",  busy_o,           1'b0);
    check("mid_rst_valid", bus.flip_valid_o, 1'b0);
    check("mid_rst_rd_en", bus.bc_rd_en_o,   1'b0);
    rst_i = 1'b0;
    set_breaks(8'd4, 8'd2, 8'd2);
    run_txn("after_rst", base, 18'h0, 8'h00, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [35:0] cl;
      logic [11:0] lit;
      int          r;
      cl = '0;
      for (int i = 0; i < 3; i++) begin
        lit = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
        cl[12*i +: 12] = lit;
        if (lit != 12'd0) begin
          r = $urandom_range(0, 9);
          ram[lit[11:1]] = (r < 2) ? 8'd0 : (r == 2) ? 8'hFF : 8'($urandom_range(1, 254));
        end
      end
      run_txn($sformatf("rand%0d", t), cl, 18'($urandom), 8'($urandom_range(0, 255)),
              $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flip_literal_selector.md
Name: flip_literal_selector

Overview:
- Downstream neighbour of the unsat clause selector. Takes the selected unsatisfied clause (NSAT packed literal addresses) and decides which variable to flip.
- Reads the break count of each literal serially from the external break-count RAM, then applies WalkSAT selection:
  - freebie (break = 0) first;
  - otherwise noisy random pick with probability noise_i/256;
  - otherwise minimum break.
- Hands the chosen variable to the flip/update stage through a valid/ready handshake.

Parameters:
- NSAT, 3, literals per clause
- LITERAL_ADDRESS_WIDTH, 12, literal address width; bit 0 = polarity, bits [W-1:1] = variable index
- BREAK_WIDTH, 8, break-count width
- RANDOM_NUM_WIDTH, 18, PRNG word width (must be >= 16)
- NOISE_WIDTH, 8, noise probability width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- clause_valid_i  in  1  one-cycle pulse, clause_i valid
- clause_i  in  NSAT*LITERAL_ADDRESS_WIDTH  packed literals, slot 0 in LSBs
- random_i  in  RANDOM_NUM_WIDTH  PRNG word, free-running
- noise_i  in  NOISE_WIDTH  noise threshold
- bc_rd_en_o  out  1  break-RAM read enable
- bc_rd_addr_o  out  LITERAL_ADDRESS_WIDTH-1  variable index to read
- bc_rd_data_i  in  BREAK_WIDTH  break count, valid one cycle after bc_rd_en_o
- flip_valid_o  out  1  flip_var_o valid
- flip_ready_i  in  1  consumer accepts
- flip_var_o  out  LITERAL_ADDRESS_WIDTH-1  variable to flip
- flip_kind_o  out  2  0 = freebie, 1 = random, 2 = greedy, 3 = error
- busy_o  out  1  high in any state except IDLE
- debug_DROP_o  out  1  sticky: clause_valid_i arrived while busy
- clear_debug_DROP_i  in  1  clears debug_DROP_o

Behaviour:
- Reset values: all outputs 0; state IDLE; internal break registers 0.
- Empty-slot rule: a literal slot equal to all zeros is unused. It is skipped everywhere: no read issued, never selectable.
- FSM:
  - IDLE: on clause_valid_i, register clause_i and go to FETCH at slot 0.
  - FETCH: each cycle, one slot k in 0..NSAT-1. For a used slot, assert bc_rd_en_o with bc_rd_addr_o = lit[k][W-1:1]. For an unused slot, drive bc_rd_en_o low and tag the slot as unused. After slot NSAT-1, go to WAIT.
  - WAIT: latch the last read datum, then go to DECIDE.
  - DECIDE: one cycle, then go to OUTPUT.
  - OUTPUT: hold flip_valid_o, flip_var_o and flip_kind_o until flip_ready_i is high; go to IDLE on that edge.
- Data capture: the datum for slot k is captured on the edge after slot k is issued. Capture is pipelined across FETCH/WAIT with a one-bit delayed slot-valid tag.
- Latency: with acceptance edge E0, flip_valid_o rises after edge E0+NSAT+2 (edge 5 for NSAT=3). With flip_ready_i tied high, a new clause can be accepted on the edge following the handshake.
- DECIDE rules, evaluated on registered values, random_i sampled in DECIDE only:
  - Used-slot count 0: flip_kind_o = 3, flip_var_o = 0.
  - Any used slot has break = 0: pick the lowest such slot; kind 0.
  - Else if random_i[7:0] < noise_i (unsigned compare, zero-extend noise_i to 8 bits): idx = (random_i[15:8] * U) >> 8, where U = used count; pick the idx-th used slot in ascending order; kind 1. idx always < U, so no overflow.
  - Else: minimum break over used slots, ties to the lowest slot; kind 2.
- Breaks are unsigned; saturated RAM values (all ones) compare normally.
- clause_valid_i when state != IDLE: ignored, debug_DROP_o set. clear_debug_DROP_i takes priority over a simultaneous set.
- Handshake: flip_valid_o must not drop before acceptance. Outputs stay stable while flip_ready_i is low. flip_ready_i outside OUTPUT has no effect.
- Reset mid-operation: state returns to IDLE on the next edge, bc_rd_en_o is 0 that cycle, and any pending flip is discarded.

Decomposition:
- Shared package: literal field helpers (polarity bit, variable-index slice), the flip_kind encodings (FREEBIE = 0, RANDOM = 1, GREEDY = 2, ERROR = 3), and the FSM state encoding.
- One natural sub-module: flip_literal_decide, combinational over NSAT registered breaks and used flags. It produces the freebie, random and greedy picks and is instantiated in DECIDE.

Test Plan:
- Clause {lit 0x00A, 0x015, 0x020}, breaks {3,0,5}, noise 0 -> bc reads of vars 5, 10, 16 in consecutive cycles; flip_var = 10, kind 0, valid at edge E0+5.
- Breaks {4,2,2}, noise 0 -> flip_var from slot 1 (tie goes to lowest slot), kind 2.
- Breaks {4,2,7}, noise 0xFF, random_i[7:0] = 0x10, random_i[15:8] = 0xAB -> idx = (171*3)>>8 = 2; slot 2 chosen, kind 1.
- Clause with slot 1 = 0, breaks {6,-,1}, noise 0xFF, random_i[15:8] = 0xFF -> only 2 reads issued; idx = 1 selects slot 2; kind 1. All-zero clause -> kind 3 with no reads.
- flip_ready_i held low 4 cycles -> outputs stable, then the handshake completes. A clause_valid_i pulse during the wait sets debug_DROP_o; clear_debug_DROP_i then clears it.
- rst_i asserted during FETCH -> next cycle busy_o = 0, flip_valid_o = 0, bc_rd_en_o = 0; a following clause completes normally.
